// File: rtl/lcd_responder.sv
// ============================================================================
// lcd_responder
// ----------------------------------------------------------------------------
// Controller-side end of an HD44780-style 4-bit LCD bus. E/RS/RW/D from the
// initiator are synchronised onto CLK. Write nibbles are latched on the
// falling edge of E and reassembled into bytes. The responder tracks the
// DDRAM address counter and the 4/8-bit interface mode, and models the
// controller busy time. During reads it drives the busy flag and the address
// counter back onto the bus.
//
// Optional feature macro:
//   LCD_RESPONDER_BUSY_EN - when defined, the busy counter is built. When
//                           undefined, busy is tied low, overrun never fires
//                           and the read status nibble has bit3 = 0.
//
// Parameters:
//   BUSY_CYCLES   busy duration after an ordinary byte
//   CLEAR_CYCLES  busy duration after clear (0x01) or return home (0x02/0x03)
//
// Ports:
//   CLK           system clock, rising edge
//   RESET         synchronous active-high reset
//   LCD_E         enable strobe (asynchronous, sampled on CLK)
//   LCD_RS        register select: 0 = instruction/status, 1 = data
//   LCD_RW        1 = read, 0 = write
//   LCD_D_IN      bus nibble as seen by the responder
//   LCD_D_OUT     read nibble driven onto the bus
//   LCD_D_OE      output enable for LCD_D_OUT
//   byte_valid    one-cycle pulse when a write byte completes
//   byte_data     last completed write byte (held until the next one)
//   byte_rs       RS of the last completed byte
//   mode4bit      1 = 4-bit interface active
//   busy          busy flag
//   addr          address counter (AC)
//   protocol_err  one-cycle pulse when RS/RW change between nibbles of a byte
//   overrun       one-cycle pulse when a byte completes while busy
// ============================================================================
module lcd_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [3:0] LCD_D_IN,
    output logic [3:0] LCD_D_OUT,
    output logic       LCD_D_OE,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       mode4bit,
    output logic       busy,
    output logic [6:0] addr,
    output logic       protocol_err,
    output logic       overrun
);

    // Nibble phase within a byte; only advances in 4-bit mode.
    typedef enum logic {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } phase_t;

    logic       e_meta, e_s, e_d;
    logic       rs_meta, rs_s;
    logic       rw_meta, rw_s;
    logic [3:0] d_meta, d_s;

    phase_t     ph;
    logic       rs_q, rw_q;
    logic       rs_first, rw_first;
    logic [3:0] hi;

    // A completed byte is staged for one cycle before it is applied, which
    // places the visible update three edges after E is first sampled low.
    logic       cmp_valid;
    logic [7:0] cmp_byte;
    logic       cmp_rs;

    logic       rise, fall;
    logic       nibble_mismatch;
    logic       clear_home;

    // Two-flop synchronisers for every bus input, plus the delayed E copy
    // used for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            e_meta  <= 1'b0;
            e_s     <= 1'b0;
            e_d     <= 1'b0;
            rs_meta <= 1'b0;
            rs_s    <= 1'b0;
            rw_meta <= 1'b0;
            rw_s    <= 1'b0;
            d_meta  <= 4'h0;
            d_s     <= 4'h0;
        end else begin
            e_meta  <= LCD_E;
            e_s     <= e_meta;
            e_d     <= e_s;
            rs_meta <= LCD_RS;
            rs_s    <= rs_meta;
            rw_meta <= LCD_RW;
            rw_s    <= rw_meta;
            d_meta  <= LCD_D_IN;
            d_s     <= d_meta;
        end
    end

    assign rise            = e_s & ~e_d;
    assign fall            = ~e_s & e_d;
    assign nibble_mismatch = (rs_s != rs_first) || (rw_s != rw_first);
    assign clear_home      = ~cmp_rs &
                             ((cmp_byte == 8'h01) || (cmp_byte[7:1] == 7'h01));

    // The bus direction simply follows the synchronised RW line.
    assign LCD_D_OE = rw_s;

    // Main protocol engine: byte application, strobe handling and read data.
    // Later statements win, so a strobe edge coinciding with byte
    // application takes precedence over the function-set phase clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ph           <= PH_HIGH;
            rs_q         <= 1'b0;
            rw_q         <= 1'b0;
            rs_first     <= 1'b0;
            rw_first     <= 1'b0;
            hi           <= 4'h0;
            cmp_valid    <= 1'b0;
            cmp_byte     <= 8'h00;
            cmp_rs       <= 1'b0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'h00;
            byte_rs      <= 1'b0;
            mode4bit     <= 1'b0;
            addr         <= 7'h00;
            protocol_err <= 1'b0;
            overrun      <= 1'b0;
            LCD_D_OUT    <= 4'h0;
        end else begin
            byte_valid   <= 1'b0;
            protocol_err <= 1'b0;
            overrun      <= 1'b0;
            cmp_valid    <= 1'b0;

            if (cmp_valid) begin
                byte_valid <= 1'b1;
                byte_data  <= cmp_byte;
                byte_rs    <= cmp_rs;
                overrun    <= busy;
                if (cmp_rs) begin
                    addr <= addr + 7'd1;
                end else if (clear_home) begin
                    addr <= 7'h00;
                end else if (cmp_byte[7]) begin
                    addr <= cmp_byte[6:0];
                end else if (cmp_byte[7:5] == 3'b001) begin
                    mode4bit <= ~cmp_byte[4];
                    ph       <= PH_HIGH;
                end
            end

            // A second nibble whose RS/RW disagree with the first one
            // restarts the byte: this strobe becomes the new high nibble.
            if (rise) begin
                rs_q <= rs_s;
                rw_q <= rw_s;
                if (ph == PH_LOW && nibble_mismatch) begin
                    protocol_err <= 1'b1;
                    ph           <= PH_HIGH;
                end
                if (ph == PH_HIGH || nibble_mismatch) begin
                    rs_first <= rs_s;
                    rw_first <= rw_s;
                end
            end

            if (fall) begin
                if (!rw_q) begin
                    if (!mode4bit) begin
                        cmp_valid <= 1'b1;
                        cmp_byte  <= {d_s, 4'h0};
                        cmp_rs    <= rs_q;
                    end else if (ph == PH_HIGH) begin
                        hi <= d_s;
                        ph <= PH_LOW;
                    end else begin
                        cmp_valid <= 1'b1;
                        cmp_byte  <= {hi, d_s};
                        cmp_rs    <= rs_q;
                        ph        <= PH_HIGH;
                    end
                end else if (mode4bit) begin
                    ph <= (ph == PH_HIGH) ? PH_LOW : PH_HIGH;
                end
            end

            // Read data is refreshed every cycle while E is high so that the
            // busy flag seen by the initiator is current.
            if (e_s) begin
                if (rw_s && !rs_s) begin
                    if (mode4bit && ph == PH_LOW) begin
                        LCD_D_OUT <= addr[3:0];
                    end else begin
                        LCD_D_OUT <= {busy, addr[6:4]};
                    end
                end else begin
                    LCD_D_OUT <= 4'h0;
                end
            end
        end
    end

`ifdef LCD_RESPONDER_BUSY_EN
    localparam logic [16:0] BUSY_LOAD  = 17'(BUSY_CYCLES);
    localparam logic [16:0] CLEAR_LOAD = 17'(CLEAR_CYCLES);

    logic [16:0] busy_cnt;

    // Busy timer: every applied byte reloads it (clear/home use the long
    // count); a reload wins over the running decrement.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_cnt <= 17'd0;
        end else if (cmp_valid && clear_home) begin
            busy_cnt <= CLEAR_LOAD;
        end else if (cmp_valid) begin
            busy_cnt <= BUSY_LOAD;
        end else if (busy_cnt != 17'd0) begin
            busy_cnt <= busy_cnt - 17'd1;
        end
    end

    assign busy = (busy_cnt != 17'd0);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// ============================================================================
// tb_lcd_responder
// ----------------------------------------------------------------------------
// Directed bench for lcd_responder. Write stimulus pushes the expected byte
// event into a scoreboard queue; a monitor branch pops and compares whenever
// byte_valid is seen. Short busy counts keep the run brief.
// ============================================================================
module tb_lcd_responder;

    localparam int BUSY_T  = 40;
    localparam int CLEAR_T = 120;
`ifdef LCD_RESPONDER_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic [6:0] addr;
        logic       mode;
        logic       ovr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [3:0] LCD_D_IN;
    logic [3:0] LCD_D_OUT;
    logic       LCD_D_OE;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       mode4bit;
    logic       busy;
    logic [6:0] addr;
    logic       protocol_err;
    logic       overrun;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   perr_count  = 0;

    lcd_responder #(
        .BUSY_CYCLES (BUSY_T),
        .CLEAR_CYCLES(CLEAR_T)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_D_IN    (LCD_D_IN),
        .LCD_D_OUT   (LCD_D_OUT),
        .LCD_D_OE    (LCD_D_OE),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_rs     (byte_rs),
        .mode4bit    (mode4bit),
        .busy        (busy),
        .addr        (addr),
        .protocol_err(protocol_err),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectByte(input logic [7:0] data, input logic rs,
                              input logic [6:0] a, input logic mode,
                              input logic ovr);
        exp_t e;
        e.data = data;
        e.rs   = rs;
        e.addr = a;
        e.mode = mode;
        e.ovr  = ovr;
        sb.push_back(e);
    endtask

    // One E strobe carrying a nibble; returns on the negedge where E drops.
    task automatic applyStimulus(input logic rs, input logic rw,
                                 input logic [3:0] nib, input int hold);
        @(negedge CLK);
        LCD_RS   = rs;
        LCD_RW   = rw;
        LCD_D_IN = nib;
        repeat (2) @(negedge CLK);
        LCD_E = 1'b1;
        repeat (hold) @(negedge CLK);
        LCD_E = 1'b0;
    endtask

    // Counts negedges until byte_valid is seen (0 if it never appears).
    task automatic waitByte(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (byte_valid && lat == 0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic writeByte4(input logic rs, input logic [7:0] b);
        int lat;
        applyStimulus(rs, 1'b0, b[7:4], 3);
        repeat (2) @(negedge CLK);
        applyStimulus(rs, 1'b0, b[3:0], 3);
        waitByte(lat);
        checkOutput("byte_latency", lat, 4);
    endtask

    task automatic writeNibble8(input logic [3:0] nib);
        int lat;
        applyStimulus(1'b0, 1'b0, nib, 3);
        waitByte(lat);
        checkOutput("byte_latency8", lat, 4);
    endtask

    // Counts cycles with busy high starting at the current negedge.
    task automatic measureBusy(output int cycles);
        cycles = 0;
        while (busy && cycles < 1000) begin
            cycles++;
            @(negedge CLK);
        end
        if (cycles >= 1000) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL busy_timeout: busy still high after %0d cycles", cycles);
        end
    endtask

    task automatic readNibble(input logic rs, output logic [3:0] nib,
                              output logic oe);
        @(negedge CLK);
        LCD_RS = rs;
        LCD_RW = 1'b1;
        repeat (2) @(negedge CLK);
        LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        nib = LCD_D_OUT;
        oe  = LCD_D_OE;
        LCD_E = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (protocol_err) perr_count++;
            if (byte_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", byte_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("byte_data", byte_data, e.data);
                    checkOutput("byte_rs", byte_rs, e.rs);
                    checkOutput("addr", addr, e.addr);
                    checkOutput("mode4bit", mode4bit, e.mode);
                    checkOutput("overrun", overrun, e.ovr);
                end
            end
        end
    endtask

    initial begin
        int         cyc;
        logic [3:0] nib;
        logic       oe;

        RESET    = 1'b1;
        LCD_E    = 1'b0;
        LCD_RS   = 1'b0;
        LCD_RW   = 1'b0;
        LCD_D_IN = 4'h0;

        fork
            monitorLoop();
            begin
                repeat (3) @(negedge CLK);
                checkOutput("rst_byte_valid", byte_valid, 0);
                checkOutput("rst_mode4bit", mode4bit, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_addr", addr, 0);
                checkOutput("rst_d_oe", LCD_D_OE, 0);
                checkOutput("rst_d_out", LCD_D_OUT, 0);
                checkOutput("rst_byte_data", byte_data, 0);
                RESET = 1'b0;
                repeat (2) @(negedge CLK);

                $display("[TB] function set to 4-bit mode");
                expectByte(8'h20, 1'b0, 7'h00, 1'b1, 1'b0);
                writeNibble8(4'h2);
                measureBusy(cyc);
                checkOutput("busy_len_fset", cyc, BUSY_EN ? BUSY_T : 0);

                $display("[TB] set DDRAM address 0x05");
                expectByte(8'h85, 1'b0, 7'h05, 1'b1, 1'b0);
                writeByte4(1'b0, 8'h85);
                measureBusy(cyc);

                $display("[TB] data write wraps address");
                expectByte(8'hFF, 1'b0, 7'h7F, 1'b1, 1'b0);
                writeByte4(1'b0, 8'hFF);
                measureBusy(cyc);
                expectByte(8'h41, 1'b1, 7'h00, 1'b1, 1'b0);
                writeByte4(1'b1, 8'h41);
                measureBusy(cyc);
                checkOutput("busy_len_data", cyc, BUSY_EN ? BUSY_T : 0);

                $display("[TB] clear display then status reads");
                expectByte(8'h01, 1'b0, 7'h00, 1'b1, 1'b0);
                writeByte4(1'b0, 8'h01);
                readNibble(1'b0, nib, oe);
                checkOutput("read1_busy", nib, BUSY_EN ? 4'h8 : 4'h0);
                checkOutput("read1_oe", oe, 1);
                readNibble(1'b0, nib, oe);
                checkOutput("read2_ac", nib, 4'h0);
                measureBusy(cyc);
                readNibble(1'b0, nib, oe);
                checkOutput("read3_idle", nib, 4'h0);
                readNibble(1'b0, nib, oe);
                checkOutput("read4_ac", nib, 4'h0);

                $display("[TB] return home busy length");
                expectByte(8'h02, 1'b0, 7'h00, 1'b1, 1'b0);
                writeByte4(1'b0, 8'h02);
                measureBusy(cyc);
                checkOutput("busy_len_home", cyc, BUSY_EN ? CLEAR_T : 0);

                $display("[TB] overrun while busy");
                expectByte(8'h06, 1'b0, 7'h00, 1'b1, 1'b0);
                writeByte4(1'b0, 8'h06);
                expectByte(8'h55, 1'b1, 7'h01, 1'b1, BUSY_EN);
                writeByte4(1'b1, 8'h55);
                measureBusy(cyc);
                checkOutput("busy_len_ovr", cyc, BUSY_EN ? BUSY_T : 0);

                $display("[TB] RS change between nibbles");
                applyStimulus(1'b0, 1'b0, 4'h8, 3);
                repeat (2) @(negedge CLK);
                applyStimulus(1'b1, 1'b0, 4'hC, 3);
                repeat (6) @(negedge CLK);
                checkOutput("protocol_err_cnt", perr_count, 1);
                expectByte(8'hC3, 1'b1, 7'h02, 1'b1, 1'b0);
                applyStimulus(1'b1, 1'b0, 4'h3, 3);
                repeat (6) @(negedge CLK);
                measureBusy(cyc);

                $display("[TB] reset after a lone high nibble");
                applyStimulus(1'b0, 1'b0, 4'h4, 3);
                repeat (6) @(negedge CLK);
                RESET = 1'b1;
                repeat (3) @(negedge CLK);
                RESET = 1'b0;
                repeat (2) @(negedge CLK);
                checkOutput("rst2_mode4bit", mode4bit, 0);
                checkOutput("rst2_addr", addr, 0);
                expectByte(8'h30, 1'b0, 7'h00, 1'b0, 1'b0);
                writeNibble8(4'h3);
                measureBusy(cyc);
                expectByte(8'h20, 1'b0, 7'h00, 1'b1, 1'b0);
                writeNibble8(4'h2);
                readNibble(1'b0, nib, oe);
                checkOutput("rst2_status", nib, BUSY_EN ? 4'h8 : 4'h0);
                readNibble(1'b0, nib, oe);
                checkOutput("rst2_ac_low", nib, 4'h0);
                measureBusy(cyc);

                repeat (8) @(negedge CLK);
                checkOutput("protocol_err_final", perr_count, 1);
                checkOutput("sb_drained", sb.size(), 0);
            end
        join_any

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
